pipe_controller: RTL

PIPE_CONTROLLER -- requirements
Module: pipe_controller

---
 rtl/pipe_controller_if.sv | 54 +++++
 rtl/pipe_controller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_controller_if.sv
// Control/hazard bundle between the datapath and pipe_controller.
// master = datapath side, slave = controller side.
interface pipe_controller_if #(
  parameter int ALUCTL_W = 3,
  parameter int RA_W     = 5
);
  logic [5:0]          op_d;
  logic [5:0]          funct_d;
  logic [RA_W-1:0]     rs_d;
  logic [RA_W-1:0]     rt_d;
  logic [RA_W-1:0]     rs_e;
  logic [RA_W-1:0]     rt_e;
  logic [RA_W-1:0]     writereg_e;
  logic [RA_W-1:0]     writereg_m;
  logic [RA_W-1:0]     writereg_w;
  logic                zero_e;

  logic                jump_d;
  logic                alusrc_e;
  logic                regdst_e;
  logic [ALUCTL_W-1:0] alucontrol_e;
  logic                pcsrc_e;
  logic                memwrite_m;
  logic                regwrite_w;
  logic                memtoreg_w;
  logic                stall_f;
  logic                stall_d;
  logic                flush_d;
  logic                flush_e;
  logic [1:0]          forward_a_e;
  logic [1:0]          forward_b_e;

  modport master (
    output op_d, funct_d, rs_d, rt_d,
    output rs_e, rt_e, writereg_e,
    output writereg_m, writereg_w, zero_e,
    input  jump_d, alusrc_e, regdst_e,
    input  alucontrol_e, pcsrc_e,
    input  memwrite_m, regwrite_w, memtoreg_w,
    input  stall_f, stall_d, flush_d, flush_e,
    input  forward_a_e, forward_b_e
  );

  modport slave (
    input  op_d, funct_d, rs_d, rt_d,
    input  rs_e, rt_e, writereg_e,
    input  writereg_m, writereg_w, zero_e,
    output jump_d, alusrc_e, regdst_e,
    output alucontrol_e, pcsrc_e,
    output memwrite_m, regwrite_w, memtoreg_w,
    output stall_f, stall_d, flush_d, flush_e,
    output forward_a_e, forward_b_e
  );
endinterface

// File: rtl/pipe_controller.sv
// 5-stage MIPS-style control: decode, D/E/M/W control pipe, hazards.
// Optional BNE support is enabled with `define PIPE_CTRL_BNE_EN.
module pipe_controller #(
  parameter int ALUCTL_W = 3,
  parameter int RA_W     = 5
) (
  input logic         clk,
  input logic         reset_n,
  pipe_controller_if.slave bus
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef PIPE_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [ALUCTL_W-1:0] A_ADD = ALUCTL_W'(3'b010);
  localparam logic [ALUCTL_W-1:0] A_SUB = ALUCTL_W'(3'b110);
  localparam logic [ALUCTL_W-1:0] A_AND = ALUCTL_W'(3'b000);
  localparam logic [ALUCTL_W-1:0] A_OR  = ALUCTL_W'(3'b001);
  localparam logic [ALUCTL_W-1:0] A_SLT = ALUCTL_W'(3'b111);

  localparam logic [RA_W-1:0] R0 = '0;

  typedef struct packed {
    logic                regwrite;
    logic                regdst;
    logic                alusrc;
    logic                branch;
    logic                memwrite;
    logic                memtoreg;
`ifdef PIPE_CTRL_BNE_EN
    logic                bne;
`endif
    logic [ALUCTL_W-1:0] alu;
  } de_t;

  typedef struct packed {
    logic regwrite;
    logic memwrite;
    logic memtoreg;
  } em_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } mw_t;

  de_t                 dec;
  de_t                 de;
  em_t                 em;
  mw_t                 mw;
  logic                jump;
  logic                r_ok;
  logic [ALUCTL_W-1:0] r_alu;
  logic                lwstall;
  logic                pcsrc;
  logic                flush_e;

  always_comb begin
    r_ok  = 1'b1;
    r_alu = '0;
    case (bus.funct_d)
      F_ADD:   r_alu = A_ADD;
      F_SUB:   r_alu = A_SUB;
      F_AND:   r_alu = A_AND;
      F_OR:    r_alu = A_OR;
      F_SLT:   r_alu = A_SLT;
      default: r_ok  = 1'b0;
    endcase
  end

  // Anything not listed, including R-type with a bad funct, is a NOP.
  always_comb begin
    dec  = '0;
    jump = 1'b0;
    case (bus.op_d)
      OP_R: if (r_ok) begin
        dec.regwrite = 1'b1;
        dec.regdst   = 1'b1;
        dec.alu      = r_alu;
      end
      OP_LW: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.memtoreg = 1'b1;
        dec.alu      = A_ADD;
      end
      OP_SW: begin
        dec.alusrc   = 1'b1;
        dec.memwrite = 1'b1;
        dec.alu      = A_ADD;
      end
      OP_BEQ: begin
        dec.branch = 1'b1;
        dec.alu    = A_SUB;
      end
`ifdef PIPE_CTRL_BNE_EN
      OP_BNE: begin
        dec.branch = 1'b1;
        dec.bne    = 1'b1;
        dec.alu    = A_SUB;
      end
`endif
      OP_ADDI: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.alu      = A_ADD;
      end
      OP_ANDI: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.alu      = A_AND;
      end
      OP_ORI: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.alu      = A_OR;
      end
      OP_SLTI: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.alu      = A_SLT;
      end
      OP_J:    jump = 1'b1;
      default: ;
    endcase
  end

`ifdef PIPE_CTRL_BNE_EN
  assign pcsrc = de.branch & (bus.zero_e ^ de.bne);
`else
  assign pcsrc = de.branch & bus.zero_e;
`endif

  assign lwstall = de.memtoreg
                 & (bus.writereg_e != R0)
                 & ((bus.writereg_e == bus.rs_d)
                  | (bus.writereg_e == bus.rt_d));

  assign flush_e = lwstall | pcsrc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      de <= '0;
      em <= '0;
      mw <= '0;
    end else begin
      de          <= flush_e ? '0 : dec;
      em.regwrite <= de.regwrite;
      em.memwrite <= de.memwrite;
      em.memtoreg <= de.memtoreg;
      mw.regwrite <= em.regwrite;
      mw.memtoreg <= em.memtoreg;
    end
  end

  // M-stage result is newer than W, so it wins on a double match.
  function automatic logic [1:0] fwd(
    input logic [RA_W-1:0] src,
    input logic [RA_W-1:0] wm,
    input logic            rm,
    input logic [RA_W-1:0] ww,
    input logic            rw
  );
    if (rm && wm != R0 && wm == src)
      return 2'b10;
    else if (rw && ww != R0 && ww == src)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign bus.forward_a_e = fwd(bus.rs_e,
    bus.writereg_m, em.regwrite,
    bus.writereg_w, mw.regwrite);
  assign bus.forward_b_e = fwd(bus.rt_e,
    bus.writereg_m, em.regwrite,
    bus.writereg_w, mw.regwrite);

  assign bus.jump_d       = jump;
  assign bus.alusrc_e     = de.alusrc;
  assign bus.regdst_e     = de.regdst;
  assign bus.alucontrol_e = de.alu;
  assign bus.pcsrc_e      = pcsrc;
  assign bus.memwrite_m   = em.memwrite;
  assign bus.regwrite_w   = mw.regwrite;
  assign bus.memtoreg_w   = mw.memtoreg;
  assign bus.stall_f      = lwstall;
  assign bus.stall_d      = lwstall;
  assign bus.flush_e      = flush_e;
  assign bus.flush_d      = pcsrc | (jump & ~lwstall);

endmodule
